// File: rtl/ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// ps2_key_decoder
//
// Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
// stop) and turns make codes for the hex keys 0-9 / A-F into a 4-bit
// character address for the downstream VGA/LPF controller. The break (F0)
// and extended (E0) prefixes suppress the byte that follows them.
//
// Ports:
//   clock      in   system clock, sole clock domain
//   reset      in   asynchronous active-high reset
//   ps2_clk    in   raw PS/2 clock from the connector (asynchronous)
//   ps2_data   in   raw PS/2 data from the connector (asynchronous)
//   clear_key  in   level acknowledge from downstream; clears temp_key
//   char_addr  out  hex value of the last accepted key (held between keys)
//   temp_key   out  sticky "new key available" flag
//   key_code   out  last correctly framed scan byte, raw
//   frame_err  out  one-cycle pulse on start/parity/stop/timeout error
//
// Latency: a key lands on temp_key/char_addr on the 4th rising clock edge
// after the stop-bit falling edge at the pin (2 sync edges, 1 receiver edge,
// 1 decode edge).
// ----------------------------------------------------------------------------
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       clear_key,
    output logic [3:0] char_addr,
    output logic       temp_key,
    output logic [7:0] key_code,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    // Returns {hit, hex value} for a make code; hit=0 for unmapped bytes.
    function automatic logic [4:0] map_key(input logic [7:0] code);
        case (code)
            8'h45:   map_key = {1'b1, 4'h0};
            8'h16:   map_key = {1'b1, 4'h1};
            8'h1E:   map_key = {1'b1, 4'h2};
            8'h26:   map_key = {1'b1, 4'h3};
            8'h25:   map_key = {1'b1, 4'h4};
            8'h2E:   map_key = {1'b1, 4'h5};
            8'h36:   map_key = {1'b1, 4'h6};
            8'h3D:   map_key = {1'b1, 4'h7};
            8'h3E:   map_key = {1'b1, 4'h8};
            8'h46:   map_key = {1'b1, 4'h9};
            8'h1C:   map_key = {1'b1, 4'hA};
            8'h32:   map_key = {1'b1, 4'hB};
            8'h21:   map_key = {1'b1, 4'hC};
            8'h23:   map_key = {1'b1, 4'hD};
            8'h24:   map_key = {1'b1, 4'hE};
            8'h2B:   map_key = {1'b1, 4'hF};
            default: map_key = {1'b0, 4'h0};
        endcase
    endfunction

    // Odd parity over data plus parity bit: true when the frame is consistent.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        odd_parity_ok = ^{data, par};
    endfunction

    // ------------------------------------------------------------------
    // Input synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic                   fall_s;
    logic                   bit_s;

    // Synchronise ps2_clk/ps2_data; idle bus level is 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= {SYNC_STAGES{1'b1}};
            data_sync_q <= {SYNC_STAGES{1'b1}};
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign fall_s = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign bit_s  = data_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_e        state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             timeout_s;

    // A fall in the same cycle takes priority, since it restarts the count.
    assign timeout_s = (state_q != ST_IDLE) && !fall_s &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Receiver state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Receiver next-state logic: one bit consumed per ps2_clk fall.
    always_comb begin
        state_d = state_q;
        if (timeout_s) begin
            state_d = ST_IDLE;
        end else if (fall_s) begin
            case (state_q)
                ST_IDLE:   state_d = bit_s ? ST_IDLE : ST_DATA;
                ST_DATA:   state_d = (bitcnt_q == 3'd7) ? ST_PARITY : ST_DATA;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Receiver datapath and strobes derived from the current state.
    always_comb begin
        shift_d      = shift_q;
        bitcnt_d     = bitcnt_q;
        parity_d     = parity_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        cnt_d        = cnt_q;

        if (fall_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else if ((state_q != ST_IDLE) && !timeout_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end

        if (timeout_s) begin
            frame_err_d = 1'b1;
        end else if (fall_s) begin
            case (state_q)
                ST_IDLE: begin
                    // A fall with data high is a bad start bit.
                    if (bit_s) begin
                        frame_err_d = 1'b1;
                    end else begin
                        bitcnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d  = {bit_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                end
                ST_PARITY: begin
                    parity_d = bit_s;
                end
                ST_STOP: begin
                    if (bit_s && odd_parity_ok(shift_q, parity_q)) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    frame_err_d = 1'b0;
                end
            endcase
        end else begin
            frame_err_d = 1'b0;
        end
    end

    // Receiver datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q      <= 8'h00;
            bitcnt_q     <= 3'd0;
            parity_q     <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            parity_q     <= parity_d;
            cnt_q        <= cnt_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Decode layer: prefixes, key mapping and the temp_key handshake
    // ------------------------------------------------------------------
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [7:0] key_code_q, key_code_d;
    logic [3:0] char_addr_q, char_addr_d;
    logic       temp_key_q, temp_key_d;
    logic [4:0] map_s;

    // shift_q is stable while byte_valid_q is high (STOP does not shift).
    assign map_s = map_key(shift_q);

    // Decode next-state; a new key overrides a simultaneous clear_key.
    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        key_code_d  = key_code_q;
        char_addr_d = char_addr_q;
        temp_key_d  = clear_key ? 1'b0 : temp_key_q;

        if (byte_valid_q) begin
            key_code_d = shift_q;
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (brk_q || ext_q) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else if (map_s[4]) begin
                char_addr_d = map_s[3:0];
                temp_key_d  = 1'b1;
            end else begin
                char_addr_d = char_addr_q;
            end
        end else begin
            key_code_d = key_code_q;
        end
    end

    // Decode registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_code_q  <= 8'h00;
            char_addr_q <= 4'h0;
            temp_key_q  <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_code_q  <= key_code_d;
            char_addr_q <= char_addr_d;
            temp_key_q  <= temp_key_d;
        end
    end

    assign char_addr = char_addr_q;
    assign temp_key  = temp_key_q;
    assign key_code  = key_code_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    localparam int TO = 5000;

    logic       clock;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       clear_key;
    logic [3:0] char_addr;
    logic       temp_key;
    logic [7:0] key_code;
    logic       frame_err;

    int errs   = 0;
    int checks = 0;

    int   rise_cnt = 0;
    logic tk_prev  = 1'b0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clear_key (clear_key),
        .char_addr (char_addr),
        .temp_key  (temp_key),
        .key_code  (key_code),
        .frame_err (frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count temp_key rising edges, sampled away from the active edge.
    always @(negedge clock) begin
        if (temp_key && !tk_prev) rise_cnt <= rise_cnt + 1;
        tk_prev <= temp_key;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit: data set while clock high, then a 5-cycle low phase.
    task automatic ps2_bit(input logic b);
        @(negedge clock);
        ps2_data = b;
        repeat (4) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (5) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    // Sends a frame and returns right after the stop-bit fall at the pin.
    task automatic frame_to_stop(input logic [7:0] b, input logic flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ flip);
        @(negedge clock);
        ps2_data = 1'b1;
        repeat (4) @(negedge clock);
        ps2_clk = 1'b0;
    endtask

    task automatic stop_release();
        repeat (6) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic send_key(input logic [7:0] b);
        frame_to_stop(b, 1'b0);
        stop_release();
    endtask

    task automatic clear_pulse();
        @(negedge clock);
        clear_key = 1'b1;
        @(negedge clock);
        clear_key = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        int errs_seen;
        bit seen;

        reset     = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        clear_key = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_char_addr", 32'(char_addr), 32'h0);
        check("reset_temp_key",  32'(temp_key),  32'h0);
        check("reset_key_code",  32'(key_code),  32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // 0x45 with exact latency: nothing on edge 3, key on edge 4.
        frame_to_stop(8'h45, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("k45_edge3_temp_key", 32'(temp_key), 32'h0);
        check("k45_edge3_frame_err", 32'(frame_err), 32'h0);
        @(posedge clock);
        #1;
        check("k45_temp_key",  32'(temp_key),  32'h1);
        check("k45_char_addr", 32'(char_addr), 32'h0);
        check("k45_key_code",  32'(key_code),  32'h45);
        check("k45_frame_err", 32'(frame_err), 32'h0);
        stop_release();

        // clear_key handshake, then 0x2B -> F.
        clear_pulse();
        check("clear_temp_key",  32'(temp_key),  32'h0);
        check("clear_char_addr", 32'(char_addr), 32'h0);
        frame_to_stop(8'h2B, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("k2b_edge3_temp_key", 32'(temp_key), 32'h0);
        @(posedge clock);
        #1;
        check("k2b_temp_key",  32'(temp_key),  32'h1);
        check("k2b_char_addr", 32'(char_addr), 32'hF);
        stop_release();

        // Make 16, then break F0 16: only one rise.
        clear_pulse();
        base = rise_cnt;
        send_key(8'h16);
        check("k16_char_addr", 32'(char_addr), 32'h1);
        clear_pulse();
        send_key(8'hF0);
        send_key(8'h16);
        check("brk_rises",     32'(rise_cnt - base), 32'h1);
        check("brk_temp_key",  32'(temp_key),  32'h0);
        check("brk_char_addr", 32'(char_addr), 32'h1);
        check("brk_key_code",  32'(key_code),  32'h16);

        // Extended E0 45: discarded but key_code tracks it.
        send_key(8'hE0);
        send_key(8'h45);
        check("ext_temp_key",  32'(temp_key),  32'h0);
        check("ext_char_addr", 32'(char_addr), 32'h1);
        check("ext_key_code",  32'(key_code),  32'h45);

        // Parity error on 0x1E: one-cycle frame_err, nothing else changes.
        frame_to_stop(8'h1E, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        check("par_frame_err_hi", 32'(frame_err), 32'h1);
        @(posedge clock);
        #1;
        check("par_frame_err_lo", 32'(frame_err), 32'h0);
        check("par_temp_key",     32'(temp_key),  32'h0);
        check("par_char_addr",    32'(char_addr), 32'h1);
        check("par_key_code",     32'(key_code),  32'h45);
        stop_release();

        // Timeout: start + 3 data bits then silence.
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(negedge clock);
        ps2_data = 1'b1;
        repeat (4) @(negedge clock);
        ps2_clk = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < TO + 50) begin
            @(posedge clock);
            #1;
            n++;
            if (n == 5) ps2_clk = 1'b1;
            if (frame_err) seen = 1'b1;
        end
        check("timeout_latency", 32'(n), 32'(TO + 4));
        @(posedge clock);
        #1;
        check("timeout_pulse_end", 32'(frame_err), 32'h0);
        repeat (3) @(negedge clock);
        send_key(8'h26);
        check("k26_temp_key",  32'(temp_key),  32'h1);
        check("k26_char_addr", 32'(char_addr), 32'h3);

        // New key coinciding with clear_key wins.
        frame_to_stop(8'h23, 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        clear_key = 1'b1;
        @(posedge clock);
        #1;
        check("race_temp_key",  32'(temp_key),  32'h1);
        check("race_char_addr", 32'(char_addr), 32'hD);
        @(negedge clock);
        clear_key = 1'b0;
        @(posedge clock);
        #1;
        check("race_hold_temp_key", 32'(temp_key), 32'h1);
        stop_release();

        // Typematic overwrite while temp_key is still set.
        send_key(8'h3D);
        check("typ_temp_key",  32'(temp_key),  32'h1);
        check("typ_char_addr", 32'(char_addr), 32'h7);

        // Lone fall with data high is a bad start bit.
        @(negedge clock);
        ps2_data = 1'b1;
        repeat (4) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("badstart_frame_err", 32'(frame_err), 32'h1);
        stop_release();

        // Reset mid-frame: asynchronous clear, no frame_err afterwards.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("rst_char_addr", 32'(char_addr), 32'h0);
        check("rst_temp_key",  32'(temp_key),  32'h0);
        check("rst_key_code",  32'(key_code),  32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        errs_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (frame_err) errs_seen++;
        end
        check("rst_no_frame_err", 32'(errs_seen), 32'h0);
        send_key(8'h2E);
        check("post_rst_temp_key",  32'(temp_key),  32'h1);
        check("post_rst_char_addr", 32'(char_addr), 32'h5);
        check("post_rst_key_code",  32'(key_code),  32'h2E);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives PS/2 keyboard frames and decodes make codes for hex keys 0-9 and A-F into a 4-bit char_addr.
- Raises a sticky temp_key flag on each accepted key press.
- Sits directly upstream of the VGA/LPF controller, which waits on temp_key, checks char_addr, and acknowledges with clear_key.
- Handles start/parity/stop framing, a mid-frame timeout, and break (F0) and extended (E0) prefixes.

Parameters:
- TIMEOUT_CYCLES, 5000: idle clocks allowed between ps2_clk falling edges inside a frame before the receiver abandons it.
- SYNC_STAGES, 2: synchroniser depth for ps2_clk and ps2_data; fixed at 2 for the latency figures below.

Ports:
- clock  in  1  system clock; sole clock domain.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock from the connector; asynchronous.
- ps2_data  in  1  raw PS/2 data from the connector; asynchronous.
- clear_key  in  1  level acknowledge from the downstream controller; clears temp_key.
- char_addr  out  4  hex value of the last accepted key; holds between keys.
- temp_key  out  1  sticky "new key available" flag.
- key_code  out  8  last correctly framed scan byte, raw.
- frame_err  out  1  one-cycle pulse on a parity, start, stop or timeout error.

Behaviour:
- Reset (asynchronous, active-high):
  - char_addr=0, temp_key=0, key_code=0, frame_err=0.
  - Synchronisers are set to 1 (bus idle). Receiver goes to IDLE, break/extended flags clear, timeout counter = 0.
- Input sync: ps2_clk and ps2_data each pass through 2 flops. A third flop on ps2_clk provides falling-edge detect (fall = prev & ~sync).
- Receiver FSM; one bit is sampled on each fall:
  - IDLE: on fall, if data=0 go to DATA with bitcnt=0. If data=1, pulse frame_err and stay in IDLE.
  - DATA: shift data in LSB first; after the 8th bit go to PARITY.
  - PARITY: store the parity bit; go to STOP.
  - STOP: require data=1 and odd parity over 8 data bits + parity bit. On success raise an internal byte_valid for one cycle. On failure pulse frame_err. Either way return to IDLE.
- Timeout:
  - The counter resets on every fall and increments while the FSM is not in IDLE.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, frame_err pulses, and the partial byte is discarded.
- Decode layer, acting on byte_valid:
  - key_code is updated with every valid byte.
  - 0xE0: set the extended flag; no key is emitted.
  - 0xF0: set the break flag; no key is emitted.
  - Any other byte with break or extended set: discard it and clear both flags.
  - Otherwise map make codes as follows; any unmapped byte is ignored:
    - 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9
    - 1C→A, 32→B, 21→C, 23→D, 24→E, 2B→F
  - On a match, char_addr is loaded and temp_key is set.
- Latency: temp_key and char_addr update on the 4th rising clock edge after the stop-bit falling edge at the pin. This is exact; the bench checks it.
- Handshake:
  - temp_key stays 1 until a cycle with clear_key=1 clears it.
  - char_addr is NOT cleared by clear_key.
  - If a mapped key and clear_key occur in the same cycle, the new key wins: temp_key stays 1 and char_addr takes the new value.
  - A repeated make (typematic) while temp_key=1 overwrites char_addr; temp_key stays 1.
- Reset mid-frame aborts the frame immediately; no frame_err is produced.
- A clock-domain assumption applies: ps2_clk must be at most 1/8 of the clock frequency.

Test Plan:
- Reset then frame 0x45 (start 0, data LSB-first, parity 0, stop 1) → exactly 4 clocks after the stop fall: temp_key=1, char_addr=0, key_code=0x45, frame_err=0.
- temp_key=1, assert clear_key for 1 cycle → temp_key=0 next cycle, char_addr still 0. Then send 0x2B → temp_key=1, char_addr=0xF.
- Sequence 0x16, F0, 16 → exactly one temp_key rise, char_addr=1. Sequence E0, 0x45 → no temp_key rise; key_code=0x45.
- Frame 0x1E with the parity bit flipped → one-cycle frame_err, temp_key unchanged, char_addr unchanged.
- Send start plus 3 data bits, then hold ps2_clk high for TIMEOUT_CYCLES → frame_err pulse, FSM in IDLE. A following clean 0x26 decodes to char_addr=3.
- Mapped key on the same cycle as clear_key → temp_key stays 1, char_addr updated. Assert reset mid-frame → all outputs 0 asynchronously, no frame_err.
